// File: rtl/camera_capture.sv
// Camera capture: RGB565 byte stream (CAM_PCLK domain) to RGB332 frame-buffer writes on CLOCK.
// Optional macro CAPTURE_TEST_PATTERN_EN replaces pixel data with three colour bars.
module camera_capture #(
   parameter int SCREEN_WIDTH  = 176,
   parameter int SCREEN_HEIGHT = 144
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic [7:0]  CAM_DATA,
   input  logic        CAM_PCLK,
   input  logic        CAM_HREF,
   input  logic        CAM_VSYNC,
   output logic [7:0]  PIXEL_OUT,
   output logic [14:0] W_ADDR,
   output logic        W_EN,
   output logic        FRAME_DONE
);

   localparam int unsigned XW = $clog2(SCREEN_WIDTH + 1) + 1;
   localparam int unsigned YW = $clog2(SCREEN_HEIGHT + 1) + 1;
   localparam int unsigned AW = 15;

   typedef enum logic [1:0] {WAIT_FRAME, WAIT_LINE, BYTE_HI, BYTE_LO} state_t;

   logic [1:0] pclk_sync, href_sync, vsync_sync;
   logic [7:0] data_meta, data_s;
   logic       pclk_d, href_d, vsync_d;

   // Two-flop synchronizers plus one extra sample for edge detection
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         pclk_sync  <= '0;
         href_sync  <= '0;
         vsync_sync <= '0;
         data_meta  <= '0;
         data_s     <= '0;
         pclk_d     <= 1'b0;
         href_d     <= 1'b0;
         vsync_d    <= 1'b0;
      end else begin
         pclk_sync  <= {pclk_sync[0], CAM_PCLK};
         href_sync  <= {href_sync[0], CAM_HREF};
         vsync_sync <= {vsync_sync[0], CAM_VSYNC};
         data_meta  <= CAM_DATA;
         data_s     <= data_meta;
         pclk_d     <= pclk_sync[1];
         href_d     <= href_sync[1];
         vsync_d    <= vsync_sync[1];
      end
   end

   logic pclk_edge, href_s, href_fall, vsync_rise, vsync_fall;
   assign pclk_edge  = pclk_sync[1] & ~pclk_d;
   assign href_s     = href_sync[1];
   assign href_fall  = ~href_sync[1] & href_d;
   assign vsync_rise = vsync_sync[1] & ~vsync_d;
   assign vsync_fall = ~vsync_sync[1] & vsync_d;

   state_t         state;
   logic [XW-1:0]  x;
   logic [YW-1:0]  y;
   logic [AW-1:0]  line_base;
   logic [5:0]     hi_bits;
   logic [7:0]     pixel_c;
   logic           in_window_c;

   assign in_window_c = (x < XW'(SCREEN_WIDTH)) && (y < YW'(SCREEN_HEIGHT));

`ifdef CAPTURE_TEST_PATTERN_EN
   always_comb begin
      pixel_c = 8'h03;
      if (x < XW'(59))       pixel_c = 8'hE0;
      else if (x < XW'(118)) pixel_c = 8'h1C;
   end
`else
   // Top 3 red, 3 green, 2 blue bits of the RGB565 pair
   assign pixel_c = {hi_bits, data_s[4:3]};
`endif

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state      <= WAIT_FRAME;
         x          <= '0;
         y          <= '0;
         line_base  <= '0;
         hi_bits    <= '0;
         PIXEL_OUT  <= '0;
         W_ADDR     <= '0;
         W_EN       <= 1'b0;
         FRAME_DONE <= 1'b0;
      end else begin
         W_EN       <= 1'b0;
         FRAME_DONE <= 1'b0;
         // Frame end aborts any line in progress and wins over a coincident pixel
         if (vsync_rise && state != WAIT_FRAME) begin
            FRAME_DONE <= 1'b1;
            state      <= WAIT_FRAME;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
         end else begin
            case (state)
               WAIT_FRAME: begin
                  if (vsync_fall) begin
                     state     <= WAIT_LINE;
                     x         <= '0;
                     y         <= '0;
                     line_base <= '0;
                  end
               end
               WAIT_LINE: begin
                  if (href_s) state <= BYTE_HI;
               end
               BYTE_HI, BYTE_LO: begin
                  if (href_fall) begin
                     state <= WAIT_LINE;
                     x     <= '0;
                     if (y < YW'(SCREEN_HEIGHT)) begin
                        y         <= y + YW'(1);
                        line_base <= line_base + AW'(SCREEN_WIDTH);
                     end
                  end else if (pclk_edge && href_s) begin
                     if (state == BYTE_HI) begin
                        hi_bits <= {data_s[7:5], data_s[2:0]};
                        state   <= BYTE_LO;
                     end else begin
                        state <= BYTE_HI;
                        if (in_window_c) begin
                           W_EN      <= 1'b1;
                           PIXEL_OUT <= pixel_c;
                           W_ADDR    <= line_base + AW'(x);
                        end
                        if (x != XW'(SCREEN_WIDTH)) x <= x + XW'(1);
                     end
                  end
               end
               default: state <= WAIT_FRAME;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture: a reference model pushes expected writes to a
// scoreboard queue as bytes are driven; a monitor pops and compares each W_EN cycle.
module tb_camera_capture;

   localparam int W = 176;
   localparam int H = 144;
`ifdef CAPTURE_TEST_PATTERN_EN
   localparam bit TP = 1'b1;
`else
   localparam bit TP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  cam_data;
   logic        cam_pclk, cam_href, cam_vsync;
   logic [7:0]  pixel_out;
   logic [14:0] w_addr;
   logic        w_en, frame_done;

   typedef struct packed {
      logic [14:0] addr;
      logic [7:0]  pix;
   } wr_t;

   wr_t exp_q[$];
   int  passed = 0, total = 0;
   int  wr_cnt = 0, fd_cnt = 0, exp_fd = 0;
   int  tb_x = 0, tb_y = 0;
   bit  in_frame = 1'b0;

   camera_capture dut (
      .CLOCK(clk), .RESET(rst), .CAM_DATA(cam_data), .CAM_PCLK(cam_pclk),
      .CAM_HREF(cam_href), .CAM_VSYNC(cam_vsync), .PIXEL_OUT(pixel_out),
      .W_ADDR(w_addr), .W_EN(w_en), .FRAME_DONE(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   function automatic logic [7:0] exp_pix(input logic [7:0] hi, input logic [7:0] lo, input int x);
      logic [7:0] bars;
      bars = (x < 59) ? 8'hE0 : (x < 118) ? 8'h1C : 8'h03;
      return TP ? bars : {hi[7:5], hi[2:0], lo[4:3]};
   endfunction

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (w_en === 1'b1) begin
            wr_t e;
            wr_cnt++;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("w_addr", 32'(w_addr), 32'(e.addr));
               check("pixel_out", 32'(pixel_out), 32'(e.pix));
            end
         end
         if (frame_done === 1'b1) fd_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      cam_data = b;
      tick(3);
      cam_pclk = 1'b1;
      tick(3);
      cam_pclk = 1'b0;
   endtask

   task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
      send_byte(hi);
      if (in_frame && tb_x < W && tb_y < H)
         exp_q.push_back('{addr: 15'(tb_x + tb_y * W), pix: exp_pix(hi, lo, tb_x)});
      send_byte(lo);
      if (in_frame) tb_x++;
   endtask

   task automatic line_start();
      cam_href = 1'b1;
      tick(4);
   endtask

   task automatic line_end();
      tick(3);
      cam_href = 1'b0;
      tick(6);
      if (in_frame) begin
         tb_x = 0;
         if (tb_y < H) tb_y++;
      end
   endtask

   task automatic line(input int n, input logic [7:0] hi, input logic [7:0] lo);
      line_start();
      for (int i = 0; i < n; i++) send_pixel(hi, lo);
      line_end();
   endtask

   task automatic vsync_rise();
      cam_vsync = 1'b1;
      if (in_frame) exp_fd++;
      in_frame = 1'b0;
      tb_x = 0;
      tb_y = 0;
      tick(8);
   endtask

   task automatic vsync_fall();
      cam_vsync = 1'b0;
      in_frame = 1'b1;
      tb_x = 0;
      tb_y = 0;
      tick(8);
   endtask

   initial begin
      int w0, f0;
      rst = 1'b1; cam_data = '0; cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0;
      tick(3);
      check("rst_pixel", 32'(pixel_out), 32'd0);
      check("rst_addr", 32'(w_addr), 32'd0);
      check("rst_wen", 32'(w_en), 32'd0);
      check("rst_fdone", 32'(frame_done), 32'd0);
      rst = 1'b0;
      tick(4);

      // No capture before the first VSYNC falling edge
      line(2, 8'hF8, 8'h00);
      check("no_write_before_vsync", 32'(wr_cnt), 32'd0);

      // Single red pixel after a VSYNC pulse
      vsync_rise(); vsync_fall();
      line(1, 8'hF8, 8'h00);
      check("first_writes", 32'(wr_cnt), 32'd1);
      check("first_addr", 32'(w_addr), 32'd0);
      check("first_pix", 32'(pixel_out), 32'(exp_pix(8'hF8, 8'h00, 0)));

      // Frame spanning rows 0..143, full first and last rows, then an off-screen row
      f0 = fd_cnt;
      vsync_rise(); vsync_fall();
      check("fd_after_first_frame", 32'(fd_cnt - f0), 32'd1);
      w0 = wr_cnt;
      line(W, 8'h07, 8'hE0);
      for (int l = 1; l < H - 1; l++) line(2, 8'h07, 8'hE0);
      line(W, 8'h07, 8'hE0);
      check("last_addr", 32'(w_addr), 32'd25343);
      line(2, 8'h07, 8'hE0);
      check("frame_writes", 32'(wr_cnt - w0), 32'(2 * W + 2 * (H - 2)));
      check("addr_held", 32'(w_addr), 32'd25343);
      f0 = fd_cnt;
      vsync_rise();
      check("frame_done_once", 32'(fd_cnt - f0), 32'd1);
      vsync_fall();

      // Over-long line clips at the screen edge
      w0 = wr_cnt;
      line(180, 8'h07, 8'hE0);
      check("clip_writes", 32'(wr_cnt - w0), 32'(W));
      line(1, 8'hF8, 8'h00);
      check("next_line_addr", 32'(w_addr), 32'(W));

      // Odd byte count: trailing half pixel is discarded
      w0 = wr_cnt;
      line_start();
      send_pixel(8'hF8, 8'h00);
      send_byte(8'h07);
      line_end();
      check("odd_writes", 32'(wr_cnt - w0), 32'd1);
      line(1, 8'h07, 8'hE0);
      check("after_odd_addr", 32'(w_addr), 32'(3 * W));

      // VSYNC rising mid-line aborts the line
      f0 = fd_cnt;
      line_start();
      for (int i = 0; i < 50; i++) send_pixel(8'hF8, 8'h00);
      vsync_rise();
      cam_href = 1'b0;
      tick(6);
      check("abort_fd", 32'(fd_cnt - f0), 32'd1);
      check("abort_wen", 32'(w_en), 32'd0);
      vsync_fall();
      line(1, 8'h07, 8'hE0);
      check("abort_restart_addr", 32'(w_addr), 32'd0);

      // VSYNC edge coincides with the low-byte PCLK edge: no write
      w0 = wr_cnt; f0 = fd_cnt;
      line_start();
      send_byte(8'hF8);
      cam_data = 8'h00;
      tick(3);
      cam_pclk = 1'b1; cam_vsync = 1'b1;
      exp_fd++; in_frame = 1'b0; tb_x = 0; tb_y = 0;
      tick(3);
      cam_pclk = 1'b0;
      tick(6);
      cam_href = 1'b0;
      tick(6);
      check("prio_writes", 32'(wr_cnt - w0), 32'd0);
      check("prio_fd", 32'(fd_cnt - f0), 32'd1);
      vsync_fall();

      // Reset mid-line: outputs clear immediately, no FRAME_DONE
      line(1, 8'h07, 8'hE0);
      f0 = fd_cnt;
      line_start();
      for (int i = 0; i < 20; i++) send_pixel(8'hF8, 8'h00);
      tick(4);
      rst = 1'b1;
      #1;
      check("async_rst_addr", 32'(w_addr), 32'd0);
      check("async_rst_pixel", 32'(pixel_out), 32'd0);
      check("async_rst_wen", 32'(w_en), 32'd0);
      in_frame = 1'b0; tb_x = 0; tb_y = 0;
      tick(3);
      rst = 1'b0;
      cam_href = 1'b0;
      tick(6);
      check("rst_no_fd", 32'(fd_cnt - f0), 32'd0);
      vsync_rise(); vsync_fall();
      line(1, 8'hF8, 8'h00);
      check("rst_restart_addr", 32'(w_addr), 32'd0);

`ifdef CAPTURE_TEST_PATTERN_EN
      // Colour bars across one full line
      w0 = wr_cnt;
      line(W, 8'h07, 8'hE0);
      check("pattern_writes", 32'(wr_cnt - w0), 32'(W));
      check("pattern_last", 32'(pixel_out), 32'h03);
`endif

      tick(10);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("fd_total", 32'(fd_cnt), 32'(exp_fd));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
